// File: rtl/cpu9_if.sv
// Status bus between the cpu9 core and its environment.
// The core drives done; observers use the slave view.
interface cpu9_if;
  logic done;

  modport master (output done);
  modport slave  (input  done);
endinterface

// File: rtl/cpu9_top_level.sv
// Single-cycle accumulator CPU: 9-bit instructions, 8-bit datapath, 10 registers,
// asynchronous-read instruction ROM (im) and data RAM (dm).
module cpu9_imem #(
  parameter int DEPTH = 256
) (
  input  logic       clk,
  input  logic       we_i,
  input  logic [7:0] waddr_i,
  input  logic [8:0] wdata_i,
  input  logic [7:0] raddr_i,
  output logic [8:0] rdata_o
);
  logic [8:0] core [0:DEPTH-1];

  // Load port exists for in-system programming; the top ties it off.
  always_ff @(posedge clk) begin
    if (we_i) core[waddr_i] <= wdata_i;
  end

  assign rdata_o = core[raddr_i];
endmodule

module cpu9_dmem #(
  parameter int DEPTH = 256
) (
  input  logic       clk,
  input  logic       we_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o
);
  logic [7:0] core [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we_i) core[addr_i] <= wdata_i;
  end

  assign rdata_o = core[addr_i];
endmodule

module cpu9_top_level #(
  parameter int IM_DEPTH = 256,
  parameter int DM_DEPTH = 256
) (
  input  logic   clk,
  input  logic   start,
  cpu9_if.master bus
);
  localparam logic [3:0] R_X = 4'd0, R_Y = 4'd1, R_R = 4'd2, R_S = 4'd3;
  localparam logic [3:0] R_M = 4'd5, R_N = 4'd6, R_V = 4'd7, R_A = 4'd8, R_B = 4'd9;

  logic [7:0] pc_q, pc_d;
  logic       done_q, done_d;
  logic [7:0] regs_q [0:9];
  logic [7:0] regs_d [0:9];
  logic [7:0] rf_rd  [0:15];

  logic [8:0]  inst;
  logic [4:0]  opcode;
  logic [3:0]  operand;
  logic [7:0]  dm_addr, dm_rdata;
  logic        dm_store, dm_we;
  logic [7:0]  alu_x, alu_y, alu_res;
  logic [15:0] rol_w, ror_w, pair_w, pair_sh;
  logic        wa_en, wb_en;
  logic [3:0]  wa_idx, wb_idx;
  logic [7:0]  wa_data, wb_data;

  cpu9_imem #(.DEPTH(IM_DEPTH)) im (
    .clk(clk), .we_i(1'b0), .waddr_i(8'h00), .wdata_i(9'h000),
    .raddr_i(pc_q), .rdata_o(inst)
  );

  cpu9_dmem #(.DEPTH(DM_DEPTH)) dm (
    .clk(clk), .we_i(dm_we), .addr_i(dm_addr),
    .wdata_i(rf_rd[{1'b0, inst[2:0]}]), .rdata_o(dm_rdata)
  );

  assign opcode   = inst[8:4];
  assign operand  = inst[3:0];
  assign dm_addr  = inst[3] ? rf_rd[R_B] : rf_rd[R_A];
  assign dm_we    = dm_store && !done_q && !start;
  assign bus.done = done_q;

  // Read view of the register file: codes 10-15 are hardwired zero.
  for (genvar gi = 0; gi < 16; gi++) begin : g_rd
    if (gi < 10) begin : g_real
      assign rf_rd[gi] = regs_q[gi];
    end else begin : g_zero
      assign rf_rd[gi] = 8'h00;
    end
  end

  assign alu_x = rf_rd[R_X];
  assign alu_y = rf_rd[R_Y];
  assign rol_w = {alu_x, alu_x} << alu_y[2:0];
  assign ror_w = {alu_x, alu_x} >> alu_y[2:0];

  always_comb begin
    case (operand)
      4'd0:    alu_res = alu_x + alu_y;
      4'd1:    alu_res = alu_x - alu_y;
      4'd2:    alu_res = alu_x & alu_y;
      4'd3:    alu_res = alu_x | alu_y;
      4'd4:    alu_res = alu_x ^ alu_y;
      4'd5:    alu_res = alu_x << alu_y[2:0];
      4'd6:    alu_res = alu_x >> alu_y[2:0];
      4'd7:    alu_res = rol_w[15:8];
      4'd8:    alu_res = ror_w[7:0];
      4'd9:    alu_res = ~alu_x;
      default: alu_res = 8'h00;
    endcase
  end

  assign pair_w  = inst[3] ? {rf_rd[R_N], rf_rd[R_M]} : {rf_rd[R_S], rf_rd[R_R]};
  assign pair_sh = pair_w << inst[2:0];

  // Two write ports: wa serves every writing instruction, wb only the high half of lslc.
  always_comb begin
    pc_d     = pc_q + 8'd1;
    done_d   = done_q;
    dm_store = 1'b0;
    wa_en    = 1'b0;
    wa_idx   = operand;
    wa_data  = 8'h00;
    wb_en    = 1'b0;
    wb_idx   = R_S;
    wb_data  = 8'h00;
    if (opcode < 5'd10) begin
      wa_en   = 1'b1;
      wa_idx  = opcode[3:0];
      wa_data = (operand == opcode[3:0]) ? 8'h00 : rf_rd[operand];
    end else begin
      case (opcode)
        5'd10: begin wa_en = 1'b1; wa_idx = R_V; wa_data = {rf_rd[R_V][7:4], operand}; end
        5'd11: begin wa_en = 1'b1; wa_idx = R_V; wa_data = {operand, rf_rd[R_V][3:0]}; end
        5'd12: begin wa_en = 1'b1; wa_idx = R_R; wa_data = alu_res; end
        5'd13: begin wa_en = 1'b1; wa_idx = R_S; wa_data = alu_res; end
        5'd14: dm_store = 1'b1;
        5'd15: begin wa_en = 1'b1; wa_idx = {1'b0, inst[2:0]}; wa_data = dm_rdata; end
        5'd16: begin wa_en = 1'b1; wa_data = rf_rd[operand] + 8'd1; end
        5'd17: begin
          if ((inst[3] ? rf_rd[R_N] : rf_rd[R_S]) == 8'h00)
            pc_d = pc_q + 8'd2 + {5'd0, inst[2:0]};
        end
        5'd18: begin
          wa_en   = 1'b1;
          wa_idx  = inst[3] ? R_M : R_R;
          wa_data = pair_sh[7:0];
          wb_en   = 1'b1;
          wb_idx  = inst[3] ? R_N : R_S;
          wb_data = pair_sh[15:8];
        end
        5'd31: begin
          if (operand == 4'd1) begin
            done_d = 1'b1;
            pc_d   = pc_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Writes to codes 10-15 match no entry and are dropped.
  for (genvar gi = 0; gi < 10; gi++) begin : g_wr
    assign regs_d[gi] = (wb_en && wb_idx == 4'(gi)) ? wb_data :
                        (wa_en && wa_idx == 4'(gi)) ? wa_data : regs_q[gi];
  end

  always_ff @(posedge clk) begin
    if (start) begin
      pc_q   <= 8'h00;
      done_q <= 1'b0;
      for (int k = 0; k < 10; k++) regs_q[k] <= 8'h00;
    end else if (!done_q) begin
      pc_q   <= pc_d;
      done_q <= done_d;
      for (int k = 0; k < 10; k++) regs_q[k] <= regs_d[k];
    end
  end
endmodule

// File: tb/tb_cpu9_top_level.sv
// Runs directed and random programs on cpu9_top_level and compares data RAM,
// cycle counts and status against an instruction-level interpreter.
module tb_cpu9_top_level;
  logic clk = 1'b0;
  logic start = 1'b1;
  always #5 clk = ~clk;

  cpu9_if bus ();
  cpu9_top_level dut (.clk(clk), .start(start), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference interpreter state
  int m_im [256];
  int m_dm [256];
  int m_reg [10];
  int m_pc, m_steps;
  bit m_halt;
  int prog [256];
  int dmi [256];

  function automatic int rd(int c);
    return (c < 10) ? m_reg[c] : 0;
  endfunction

  function automatic int alu(int x, int y, int f);
    int k;
    k = y % 8;
    case (f)
      0: return (x + y) % 256;
      1: return (x - y + 256) % 256;
      2: return x & y;
      3: return x | y;
      4: return x ^ y;
      5: return (x << k) % 256;
      6: return x >> k;
      7: return ((x << k) | (x >> (8 - k))) % 256;
      8: return ((x >> k) | (x << (8 - k))) % 256;
      9: return 255 - x;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 0; m_steps = 0; m_halt = 0;
    for (int i = 0; i < 10; i++) m_reg[i] = 0;
  endtask

  task automatic model_step();
    int inst, op, opd, lo3, nxt, addr, hi, lo, p;
    if (m_halt) return;
    inst = m_im[m_pc];
    op = inst / 16; opd = inst % 16; lo3 = inst % 8;
    nxt = (m_pc + 1) % 256;
    addr = (opd >= 8) ? m_reg[9] : m_reg[8];
    m_steps++;
    if (op <= 9) m_reg[op] = (opd == op) ? 0 : rd(opd);
    else case (op)
      10: m_reg[7] = (m_reg[7] / 16) * 16 + opd;
      11: m_reg[7] = opd * 16 + m_reg[7] % 16;
      12: m_reg[2] = alu(m_reg[0], m_reg[1], opd);
      13: m_reg[3] = alu(m_reg[0], m_reg[1], opd);
      14: m_dm[addr] = m_reg[lo3];
      15: m_reg[lo3] = m_dm[addr];
      16: if (opd < 10) m_reg[opd] = (m_reg[opd] + 1) % 256;
      17: if (((opd >= 8) ? m_reg[6] : m_reg[3]) == 0) nxt = (m_pc + 2 + lo3) % 256;
      18: begin
        hi = (opd >= 8) ? m_reg[6] : m_reg[3];
        lo = (opd >= 8) ? m_reg[5] : m_reg[2];
        p = ((hi * 256 + lo) * (1 << lo3)) % 65536;
        if (opd >= 8) begin m_reg[6] = p / 256; m_reg[5] = p % 256; end
        else begin m_reg[3] = p / 256; m_reg[2] = p % 256; end
      end
      31: if (opd == 1) begin m_halt = 1; nxt = m_pc; end
      default: ;
    endcase
    m_pc = nxt;
  endtask

  task automatic install();
    for (int i = 0; i < 256; i++) begin
      dut.im.core[i] = prog[i][8:0];
      m_im[i] = prog[i];
      dut.dm.core[i] = dmi[i][7:0];
      m_dm[i] = dmi[i];
    end
  endtask

  task automatic do_reset(string tag);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    model_reset();
    check_eq({tag, "/rst_done"}, 32'(bus.done), 32'd0);
    check_eq({tag, "/rst_pc"}, 32'(dut.pc_q), 32'd0);
    for (int k = 0; k < 10; k++)
      check_eq($sformatf("%s/rst_reg%0d", tag, k), 32'(dut.regs_q[k]), 32'd0);
  endtask

  task automatic run_check(string tag);
    int cyc;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    while (!m_halt && m_steps < 3000) model_step();
    check_eq({tag, "/cycles"}, 32'(cyc), 32'(m_steps));
    check_eq({tag, "/done"}, 32'(bus.done), 32'd1);
    // Extra cycles after halt must change nothing.
    repeat (4) @(posedge clk);
    #1;
    check_eq({tag, "/done_hold"}, 32'(bus.done), 32'd1);
    check_eq({tag, "/pc_hold"}, 32'(dut.pc_q), 32'(m_pc));
    for (int i = 0; i < 256; i++)
      check_eq($sformatf("%s/dm[%0d]", tag, i), 32'(dut.dm.core[i]), 32'(m_dm[i]));
    $display("txn %s: %0d instructions, pc=%0d", tag, cyc, m_pc);
  endtask

  task automatic random_prog();
    for (int i = 0; i < 256; i++) begin
      prog[i] = (i < 40) ? int'($urandom_range(0, 511)) : 'h1F1;
      dmi[i] = int'($urandom_range(0, 255));
    end
  endtask

  localparam int DIR_LEN = 42;
  int dir [DIR_LEN] = '{
    'h077, 'h0AC, 'h0B3, 'h007, 'h077, 'h0A2, 'h017, 'h0C8, 'h0E2, 'h0AF,
    'h017, 'h0D2, 'h108, 'h0E3, 'h000, 'h0D2, 'h108, 'h1F0, 'h112, 'h0BF,
    'h047, 'h1F0, 'h0E4, 'h109, 'h080, 'h0F0, 'h0F9, 'h0C0, 'h109, 'h109,
    'h0EA, 'h077, 'h0BA, 'h0A0, 'h057, 'h077, 'h0AF, 'h067, 'h12C, 'h109,
    'h0EE, 'h1F1
  };

  initial begin
    for (int i = 0; i < 256; i++) begin
      prog[i] = (i < DIR_LEN) ? dir[i] : 'h1F1;
      dmi[i] = 0;
    end
    install();
    do_reset("dir");
    run_check("dir");
    check_eq("dir/rotate", 32'(dut.dm.core[0]), 32'h0F);
    check_eq("dir/amp", 32'(dut.dm.core[1]), 32'h0C);
    check_eq("dir/jizr_skip", 32'(dut.dm.core[2]), 32'h00);
    check_eq("dir/load_add", 32'(dut.dm.core[3]), 32'h1B);
    check_eq("dir/lslc", 32'(dut.dm.core[4]), 32'hFA);
    check_eq("dir/halt_pc", 32'(dut.pc_q), 32'd41);

    for (int t = 0; t < 8; t++) begin
      random_prog();
      install();
      do_reset($sformatf("rnd%0d", t));
      run_check($sformatf("rnd%0d", t));
    end

    // Reset in the middle of a run: memory effects persist, core restarts.
    for (int t = 0; t < 3; t++) begin
      int k;
      random_prog();
      install();
      do_reset($sformatf("mid%0d_a", t));
      k = int'($urandom_range(3, 20));
      repeat (k) @(posedge clk);
      #1;
      for (int j = 0; j < k; j++) model_step();
      do_reset($sformatf("mid%0d_b", t));
      run_check($sformatf("mid%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
